// File: rtl/seq_divider_16bit_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DefaultWidth : default operand / quotient / remainder width
//   StIdle/StCalc/StDone : FSM state encodings
//   cnt_width()  : iteration counter width for a given operand width
package seq_divider_16bit_pkg;

    localparam int unsigned DefaultWidth = 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

    localparam int unsigned CntWidth = cnt_width(DefaultWidth);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a_i, b_i : addend bits
//   c_i      : carry in
//   sum_o    : sum bit
//   c_o      : carry out
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic sum_o,
    output logic c_o
);

    assign sum_o = a_i ^ b_i ^ c_i;
    assign c_o   = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/restoring_sub_stage.sv
// Combinational ripple-borrow subtractor: diff = a - b computed as a + ~b + 1.
//   a_i, b_i     : unsigned operands (WIDTH bits)
//   diff_o       : a - b modulo 2**WIDTH
//   no_borrow_o  : high when a >= b (final carry out)
module restoring_sub_stage #(
    parameter int unsigned WIDTH = 17
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             no_borrow_o
);

    logic [WIDTH:0] carry;

    // Carry-in of 1 completes the two's complement of b.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a_i   (a_i[i]),
            .b_i   (~b_i[i]),
            .c_i   (carry[i]),
            .sum_o (diff_o[i]),
            .c_o   (carry[i+1])
        );
    end

    assign no_borrow_o = carry[WIDTH];

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : request, accepted when not busy (IDLE or DONE)
//   dividend, divisor     : operands, sampled on the accepting edge
//   busy                  : high while iterating
//   done                  : one-cycle pulse when results are valid
//   quotient, remainder   : results, held until the next accepted start
//   div_by_zero           : set with done when the divisor was zero
module seq_divider_16bit
    import seq_divider_16bit_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   diff;
    logic             no_borrow;
    logic             take;
    logic             accept;

    // {R,Q} shifted left by one; the partial remainder is always below the
    // divisor so the shifted value fits in WIDTH+1 bits.
    assign r_shift = {r_q, q_q[WIDTH-1]};
    assign q_shift = {q_q[WIDTH-2:0], 1'b0};

    restoring_sub_stage #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a_i         (r_shift),
        .b_i         ({1'b0, divisor_q}),
        .diff_o      (diff),
        .no_borrow_o (no_borrow)
    );

    // diff[WIDTH] is always 0 when there is no borrow; checking it keeps the
    // dropped bit from ever being silently discarded.
    assign take   = no_borrow & ~diff[WIDTH];
    assign accept = start & (state_q != StCalc);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        r_d         = r_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        if (state_q == StCalc) begin
            r_d     = take ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
            q_d     = {q_shift[WIDTH-1:1], take};
            count_d = count_q + CntW'(1);
            if (count_q == CntW'(WIDTH - 1)) begin
                state_d     = StDone;
                quotient_d  = q_d;
                remainder_d = r_d;
            end
        end else if (accept) begin
            if (divisor == '0) begin
                state_d     = StDone;
                quotient_d  = '1;
                remainder_d = dividend;
                dbz_d       = 1'b1;
            end else begin
                state_d   = StCalc;
                count_d   = '0;
                r_d       = '0;
                q_d       = dividend;
                divisor_d = divisor;
                dbz_d     = 1'b0;
            end
        end else if (state_q == StDone) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            count_q     <= '0;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            r_q         <= r_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == StCalc);
    assign done        = (state_q == StDone);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed self-checking bench for seq_divider_16bit.
module tb_seq_divider_16bit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider_16bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue start at the current time (just after an edge), check busy for
    // the 16 iteration cycles, and finish in the done cycle.
    task automatic run_div(input string tag, input logic [15:0] dd, input logic [15:0] dv,
                           input logic [15:0] exp_q, input logic [15:0] exp_r);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        tick();
        start    = 1'b0;
        dividend = 16'hxxxx;
        divisor  = 16'hxxxx;
        check({tag, " busy@E0"}, busy, 1);
        check({tag, " done@E0"}, done, 0);
        for (int i = 1; i < 16; i++) begin
            tick();
            check({tag, " busy"}, busy, 1);
        end
        tick();
        check({tag, " done"}, done, 1);
        check({tag, " busy@done"}, busy, 0);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " dbz"}, div_by_zero, 0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        rst = 1'b0;
        tick();

        run_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2);
        tick();
        check("100/7 done falls", done, 0);
        check("100/7 q held", quotient, 16'd14);
        check("100/7 r held", remainder, 16'd2);

        run_div("FFFF/1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0);
        tick();
        run_div("FFFF/FFFF", 16'hFFFF, 16'hFFFF, 16'd1, 16'd0);
        tick();

        // Divide by zero: done right after the accepting edge, no busy.
        start    = 1'b1;
        dividend = 16'd5;
        divisor  = 16'd0;
        tick();
        start    = 1'b0;
        check("5/0 done", done, 1);
        check("5/0 busy", busy, 0);
        check("5/0 dbz", div_by_zero, 1);
        check("5/0 quotient", quotient, 16'hFFFF);
        check("5/0 remainder", remainder, 16'd5);
        tick();
        check("5/0 done falls", done, 0);
        check("5/0 busy stays low", busy, 0);
        check("5/0 dbz held", div_by_zero, 1);
        check("5/0 r held", remainder, 16'd5);

        // Back-to-back: second start issued in the done cycle of the first.
        run_div("3/10", 16'd3, 16'd10, 16'd0, 16'd3);
        run_div("1000/33 b2b", 16'd1000, 16'd33, 16'd30, 16'd10);
        tick();
        check("b2b done falls", done, 0);

        // Start while busy is ignored.
        start    = 1'b1;
        dividend = 16'd50000;
        divisor  = 16'd123;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        start    = 1'b1;
        dividend = 16'd9;
        divisor  = 16'd3;
        tick();
        start = 1'b0;
        check("ignore busy", busy, 1);
        for (int i = 6; i < 16; i++) tick();
        check("ignore busy@E15", busy, 1);
        tick();
        check("ignore done", done, 1);
        check("ignore quotient", quotient, 16'd406);
        check("ignore remainder", remainder, 16'd62);
        tick();

        // Reset mid-operation aborts and clears results.
        start    = 1'b1;
        dividend = 16'd1234;
        divisor  = 16'd5;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        check("abort busy before rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort quotient", quotient, 0);
        check("abort remainder", remainder, 0);
        begin
            int seen_done = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (done || busy) seen_done++;
            end
            check("abort no done", seen_done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
